// File: rtl/bsg_idiv_pkg.sv
// Shared types for the iterative-divider request front-end.
package bsg_idiv_pkg;

  typedef enum logic [1:0] {
    eDIV  = 2'd0,
    eDIVU = 2'd1,
    eREM  = 2'd2,
    eREMU = 2'd3
  } bsg_idiv_op_e;

  typedef enum logic [1:0] {
    eIdle   = 2'd0,
    eIssue  = 2'd1,
    eWait   = 2'd2,
    eResult = 2'd3
  } bsg_idiv_fe_state_e;

  function automatic logic op_is_signed(input bsg_idiv_op_e op);
    return (op == eDIV) || (op == eREM);
  endfunction

  function automatic logic op_is_rem(input bsg_idiv_op_e op);
    return (op == eREM) || (op == eREMU);
  endfunction

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Register bank with synchronous active-high reset to zero and load enable.
module bsg_dff_reset_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] r_data;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_data <= '0;
    end else if (en_i) begin
      r_data <= data_i;
    end
  end

  assign data_o = r_data;

endmodule

// File: rtl/bsg_idiv_frontend.sv
// Request front-end for the iterative divider: resolves divide-by-zero and
// signed overflow locally, forwards the rest, and returns quotient or remainder.
module bsg_idiv_frontend
  import bsg_idiv_pkg::*;
#(
  parameter int width_p     = 64,
  parameter int tag_width_p = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [1:0]             op_i,
  input  logic [width_p-1:0]     dividend_i,
  input  logic [width_p-1:0]     divisor_i,
  input  logic [tag_width_p-1:0] tag_i,
  output logic                   div_v_o,
  input  logic                   div_ready_i,
  output logic [width_p-1:0]     div_dividend_o,
  output logic [width_p-1:0]     div_divisor_o,
  output logic                   div_signed_o,
  input  logic                   div_v_i,
  input  logic [width_p-1:0]     div_quotient_i,
  input  logic [width_p-1:0]     div_remainder_i,
  output logic                   div_yumi_o,
  output logic                   v_o,
  output logic [width_p-1:0]     data_o,
  output logic [tag_width_p-1:0] tag_o,
  input  logic                   yumi_i
);

  localparam logic [width_p-1:0] MinSigned = {1'b1, {(width_p-1){1'b0}}};

  bsg_idiv_fe_state_e r_state;

  bsg_idiv_op_e       w_op_in;
  bsg_idiv_op_e       w_op_held;
  logic               w_accept;
  logic               w_div_zero;
  logic               w_overflow;
  logic               w_fast;
  logic               w_div_done;
  logic [width_p-1:0] w_fast_data;
  logic [width_p-1:0] w_result_next;
  logic               w_result_en;
  logic [1:0]         w_op_reg;

  assign w_op_in    = bsg_idiv_op_e'(op_i);
  assign w_op_held  = bsg_idiv_op_e'(w_op_reg);

  assign ready_o    = (r_state == eIdle) && !reset_i;
  assign v_o        = (r_state == eResult);
  assign div_v_o    = (r_state == eIssue);
  assign w_div_done = (r_state == eWait) && div_v_i;
  assign div_yumi_o = w_div_done;

  assign w_accept   = ready_o && v_i;
  assign w_div_zero = (divisor_i == '0);
  assign w_overflow = op_is_signed(w_op_in) && (dividend_i == MinSigned) && (divisor_i == '1);
  assign w_fast     = w_div_zero || w_overflow;

  // Divide-by-zero takes priority; the two cases cannot overlap anyway.
  always_comb begin
    w_fast_data = '0;
    if (w_div_zero) begin
      w_fast_data = op_is_rem(w_op_in) ? dividend_i : '1;
    end else if (w_overflow) begin
      w_fast_data = op_is_rem(w_op_in) ? '0 : dividend_i;
    end
  end

  assign w_result_en   = (w_accept && w_fast) || w_div_done;
  assign w_result_next = (r_state == eIdle) ? w_fast_data
                       : (op_is_rem(w_op_held) ? div_remainder_i : div_quotient_i);

  // Operands are only loaded for requests that actually go to the divider.
  bsg_dff_reset_en #(.width_p(2*width_p+1)) operand_reg (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (w_accept && !w_fast),
    .data_i ({dividend_i, divisor_i, op_is_signed(w_op_in)}),
    .data_o ({div_dividend_o, div_divisor_o, div_signed_o})
  );

  bsg_dff_reset_en #(.width_p(2+tag_width_p)) ctl_reg (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (w_accept),
    .data_i ({op_i, tag_i}),
    .data_o ({w_op_reg, tag_o})
  );

  bsg_dff_reset_en #(.width_p(width_p)) result_reg (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (w_result_en),
    .data_i (w_result_next),
    .data_o (data_o)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= eIdle;
    end else begin
      unique case (r_state)
        eIdle:   if (v_i) r_state <= w_fast ? eResult : eIssue;
        eIssue:  if (div_ready_i) r_state <= eWait;
        eWait:   if (div_v_i) r_state <= eResult;
        eResult: if (yumi_i) r_state <= eIdle;
        default: r_state <= eIdle;
      endcase
    end
  end

  // A divider result outside eWait means the divider and front-end disagree.
  a_div_v_only_in_wait: assert property (
    @(posedge clk_i) disable iff (reset_i) div_v_i |-> (r_state == eWait)
  ) else $error("div_v_i asserted outside eWait");

endmodule

// File: tb/tb_bsg_idiv_frontend.sv
// Directed-vector bench for bsg_idiv_frontend with a variable-latency divider model.
module tb_bsg_idiv_frontend;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          v_i;
  logic          ready_o;
  logic [1:0]    op_i;
  logic [W-1:0]  dividend_i;
  logic [W-1:0]  divisor_i;
  logic [TW-1:0] tag_i;
  logic          div_v_o;
  logic          div_ready_i;
  logic [W-1:0]  div_dividend_o;
  logic [W-1:0]  div_divisor_o;
  logic          div_signed_o;
  logic          div_v_i;
  logic [W-1:0]  div_quotient_i;
  logic [W-1:0]  div_remainder_i;
  logic          div_yumi_o;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic [TW-1:0] tag_o;
  logic          yumi_i;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bsg_idiv_frontend #(.width_p(W), .tag_width_p(TW)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .v_i            (v_i),
    .ready_o        (ready_o),
    .op_i           (op_i),
    .dividend_i     (dividend_i),
    .divisor_i      (divisor_i),
    .tag_i          (tag_i),
    .div_v_o        (div_v_o),
    .div_ready_i    (div_ready_i),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_signed_o   (div_signed_o),
    .div_v_i        (div_v_i),
    .div_quotient_i (div_quotient_i),
    .div_remainder_i(div_remainder_i),
    .div_yumi_o     (div_yumi_o),
    .v_o            (v_o),
    .data_o         (data_o),
    .tag_o          (tag_o),
    .yumi_i         (yumi_i)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_i = 1'b1; v_i = 1'b0; op_i = 2'd0; dividend_i = '0; divisor_i = '0;
    tag_i = '0; div_ready_i = 1'b0; div_v_i = 1'b0; div_quotient_i = '0;
    div_remainder_i = '0; yumi_i = 1'b0;
    @(negedge clk);
    tick();
    vectors++;
    if (ready_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready_low: got %0b want 0", ready_o);
    end
    reset_i = 1'b0;
    #1;
    vectors++;
    if ({ready_o, v_o, div_v_o, div_yumi_o} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_valids: got ready/v/div_v/yumi=%b want 1000", {ready_o, v_o, div_v_o, div_yumi_o});
    end
    vectors++;
    if ({data_o, tag_o, div_dividend_o, div_divisor_o, div_signed_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got data=%h tag=%h dvd=%h dvs=%h sgn=%b want 0", data_o, tag_o, div_dividend_o, div_divisor_o, div_signed_o);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] tag, input logic fast,
                        input int rdy_dly, input int lat, input int hold, input logic [W-1:0] exp);
    logic          exp_signed;
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic [W-1:0]  cap_a;
    logic [W-1:0]  cap_b;
    logic          cap_s;
    exp_signed = (op == 2'd0) || (op == 2'd2);
    vectors++;
    if (ready_o !== 1'b1) begin
      miscompares++; $display("FAIL %s ready_before: got %0b want 1", name, ready_o);
    end
    v_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; tag_i = tag;
    tick();
    v_i = 1'b0; dividend_i = '0; divisor_i = '0; tag_i = '0;
    if (fast) begin
      vectors++;
      if ({v_o, div_v_o} !== 2'b10) begin
        miscompares++; $display("FAIL %s fast_valids: got v/div_v=%b want 10", name, {v_o, div_v_o});
      end
    end else begin
      vectors++;
      if ({v_o, div_v_o, div_signed_o} !== {2'b01, exp_signed} || div_dividend_o !== a || div_divisor_o !== b) begin
        miscompares++;
        $display("FAIL %s issue: got v/div_v/sgn=%b dvd=%h dvs=%h want %b %h %h", name,
                 {v_o, div_v_o, div_signed_o}, div_dividend_o, div_divisor_o, {2'b01, exp_signed}, a, b);
      end
      for (int i = 0; i < rdy_dly; i++) begin
        tick();
        vectors++;
        if ({v_o, div_v_o} !== 2'b01 || div_dividend_o !== a) begin
          miscompares++; $display("FAIL %s issue_stall: got v/div_v=%b dvd=%h want 01 %h", name, {v_o, div_v_o}, div_dividend_o, a);
        end
      end
      cap_a = div_dividend_o; cap_b = div_divisor_o; cap_s = div_signed_o;
      if (cap_s) begin
        q = W'($signed(cap_a) / $signed(cap_b));
        r = W'($signed(cap_a) % $signed(cap_b));
      end else begin
        q = cap_a / cap_b;
        r = cap_a % cap_b;
      end
      div_ready_i = 1'b1;
      tick();
      div_ready_i = 1'b0;
      for (int i = 0; i < lat; i++) begin
        vectors++;
        if ({v_o, div_v_o, div_yumi_o} !== 3'b000) begin
          miscompares++; $display("FAIL %s wait: got v/div_v/yumi=%b want 000", name, {v_o, div_v_o, div_yumi_o});
        end
        tick();
      end
      div_v_i = 1'b1; div_quotient_i = q; div_remainder_i = r;
      #1;
      vectors++;
      if (div_yumi_o !== 1'b1) begin
        miscompares++; $display("FAIL %s div_yumi: got %0b want 1", name, div_yumi_o);
      end
      tick();
      div_v_i = 1'b0; div_quotient_i = '0; div_remainder_i = '0;
    end
    vectors++;
    if ({v_o, ready_o, div_v_o} !== 3'b100 || data_o !== exp || tag_o !== tag) begin
      miscompares++;
      $display("FAIL %s result: got v/ready/div_v=%b data=%h tag=%0d want 100 %h %0d", name,
               {v_o, ready_o, div_v_o}, data_o, tag_o, exp, tag);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      vectors++;
      if ({v_o, ready_o, div_v_o} !== 3'b100 || data_o !== exp || tag_o !== tag) begin
        miscompares++;
        $display("FAIL %s hold%0d: got v/ready/div_v=%b data=%h tag=%0d want 100 %h %0d", name, i,
                 {v_o, ready_o, div_v_o}, data_o, tag_o, exp, tag);
      end
    end
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    vectors++;
    if ({v_o, ready_o} !== 2'b01) begin
      miscompares++; $display("FAIL %s after_yumi: got v/ready=%b want 01", name, {v_o, ready_o});
    end
    $display("op %s a=%h b=%h tag=%0d -> data=%h", name, a, b, tag, data_o);
  endtask

  task automatic test_directed();
    run_op("divu_100_7",   2'd1, 32'd100,       32'd7,          5'd3,  1'b0, 0, 2, 0, 32'd14);
    run_op("rem_m100_7",   2'd2, 32'hFFFFFF9C,  32'd7,          5'd4,  1'b0, 1, 0, 0, 32'hFFFFFFFE);
    run_op("div_5_0",      2'd0, 32'd5,         32'd0,          5'd5,  1'b1, 0, 0, 0, 32'hFFFFFFFF);
    run_op("remu_5_0",     2'd3, 32'd5,         32'd0,          5'd6,  1'b1, 0, 0, 0, 32'd5);
    run_op("div_ovf",      2'd0, 32'h80000000,  32'hFFFFFFFF,   5'd7,  1'b1, 0, 0, 0, 32'h80000000);
    run_op("rem_ovf",      2'd2, 32'h80000000,  32'hFFFFFFFF,   5'd8,  1'b1, 0, 0, 0, 32'd0);
    run_op("divu_no_ovf",  2'd1, 32'h80000000,  32'hFFFFFFFF,   5'd9,  1'b0, 0, 1, 0, 32'd0);
    run_op("rem_m5_0",     2'd2, 32'hFFFFFFFB,  32'd0,          5'd10, 1'b1, 0, 0, 0, 32'hFFFFFFFB);
  endtask

  task automatic test_backpressure();
    run_op("bp_div_0_0",   2'd0, 32'd0,         32'd0,          5'd11, 1'b1, 0, 0, 10, 32'hFFFFFFFF);
    run_op("bp_remu",      2'd3, 32'hFFFFFFFF,  32'd10,         5'd12, 1'b0, 2, 3, 10, 32'd5);
  endtask

  task automatic test_stall_mix();
    run_op("div_m7_2",     2'd0, 32'hFFFFFFF9,  32'd2,          5'd13, 1'b0, 3, 5, 1, 32'hFFFFFFFD);
    run_op("rem_7_m2",     2'd2, 32'd7,         32'hFFFFFFFE,   5'd14, 1'b0, 0, 7, 0, 32'd1);
    run_op("divu_big",     2'd1, 32'hFFFFFFFF,  32'd16,         5'd15, 1'b0, 4, 1, 2, 32'h0FFFFFFF);
    run_op("remu_1000_7",  2'd3, 32'd1000,      32'd7,          5'd31, 1'b0, 1, 4, 0, 32'd6);
  endtask

  task automatic test_reset_mid();
    v_i = 1'b1; op_i = 2'd1; dividend_i = 32'd1000; divisor_i = 32'd10; tag_i = 5'd20;
    tick();
    v_i = 1'b0;
    div_ready_i = 1'b1;
    tick();
    div_ready_i = 1'b0;
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
    vectors++;
    if ({v_o, ready_o, div_v_o, div_yumi_o} !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_mid: got v/ready/div_v/yumi=%b want 0100", {v_o, ready_o, div_v_o, div_yumi_o});
    end
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    vectors++;
    if ({v_o, ready_o} !== 2'b01) begin
      miscompares++; $display("FAIL stray_yumi: got v/ready=%b want 01", {v_o, ready_o});
    end
    run_op("divu_9_3",     2'd1, 32'd9,         32'd3,          5'd21, 1'b0, 0, 2, 0, 32'd3);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_stall_mix();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
